// File: rtl/wb_if.sv
// Wishbone classic bus bundle shared by initiators and targets.
interface wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] ADR;
    logic [DATA_WIDTH-1:0] DAT_W;
    logic [DATA_WIDTH-1:0] DAT_R;
    logic                  WE;
    logic                  CYC;
    logic                  STB;
    logic                  ACK;

    modport master (
        output ADR, DAT_W, WE, CYC, STB,
        input  ACK, DAT_R
    );

    modport slave (
        input  ADR, DAT_W, WE, CYC, STB,
        output ACK, DAT_R
    );
endinterface

// File: rtl/wb_master_ctrl.sv
// Wishbone classic single-transfer initiator with ACK timeout.
// One command in flight; result returned on a valid/ready response stream.
module wb_master_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    wb_if.master                  master
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_w_q, dat_w_d;
    logic                  we_q, we_d;
    logic                  cyc_q, cyc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  accept;

    // Consuming a response and taking the next command share one edge,
    // which keeps a zero-wait target at one transfer per three cycles.
    assign req_ready = (state_q == IDLE) ||
                       ((state_q == RESP) && rsp_ready);

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_w_d     = dat_w_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                accept = req_valid;
            end
            BUS: begin
                if (master.ACK) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = we_q ? '0 : master.DAT_R;
                    state_d     = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                    accept      = req_valid;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            adr_d   = req_addr;
            dat_w_d = req_data;
            we_d    = req_we;
            cyc_d   = 1'b1;
            cnt_d   = '0;
            state_d = BUS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_w_q     <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_w_q     <= dat_w_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign master.ADR   = adr_q;
    assign master.DAT_W = dat_w_q;
    assign master.WE    = we_q;
    assign master.CYC   = cyc_q;
    assign master.STB   = cyc_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_wb_master_ctrl.sv
// Bench for wb_master_ctrl: SRAM-style target, response scoreboard,
// bus-shape monitor and directed scenarios.
module tb_wb_master_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_master_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_data(req_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .master(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Target model: ACK after slave_waits extra cycles, or never.
    logic [DW-1:0] mem [0:63];
    logic          ack_s;
    logic [DW-1:0] dat_r_s;
    int            wcnt;
    int            slave_waits = 0;
    logic          slave_never = 1'b0;
    logic          late_ack = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_s   <= 1'b0;
            wcnt    <= 0;
            dat_r_s <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (bus.CYC && bus.STB && !ack_s && !slave_never) begin
            if (wcnt == slave_waits) begin
                ack_s   <= 1'b1;
                wcnt    <= 0;
                dat_r_s <= mem[bus.ADR[7:2]];
                if (bus.WE) mem[bus.ADR[7:2]] <= bus.DAT_W;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            ack_s <= 1'b0;
            wcnt  <= 0;
        end
    end

    assign bus.ACK   = ack_s | late_ack;
    assign bus.DAT_R = dat_r_s;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    rsp_t exp_q[$];
    int   acc_q[$];
    int   last_cyc_len = 0;
    int   last_rsp_cyc = 0;
    int   last_acc_cyc = 0;

    // Monitor: scoreboard pops and bus-shape bookkeeping.
    initial begin
        int   cyc_run;
        logic rv_prev;
        rsp_t e;
        cyc_run = 0;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("stb_eq_cyc", 64'(bus.STB), 64'(bus.CYC));
                if (bus.CYC) begin
                    cyc_run++;
                end else if (cyc_run != 0) begin
                    last_cyc_len = cyc_run;
                    cyc_run = 0;
                end
                if (rsp_valid && !rv_prev) last_rsp_cyc = cyc_cnt;
                rv_prev = rsp_valid;
                if (req_valid && req_ready) begin
                    acc_q.push_back(cyc_cnt);
                    last_acc_cyc = cyc_cnt;
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got err=%0b data=0x%0h expected none",
                                 rsp_err, rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_err", 64'(rsp_err), 64'(e.err));
                        check("rsp_data", 64'(rsp_data), 64'(e.data));
                    end
                end
            end else begin
                cyc_run = 0;
                rv_prev = 1'b0;
            end
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic push,
                         input logic e_err, input logic [DW-1:0] e_data);
        req_we    = we;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        if (push) exp_q.push_back(rsp_t'{e_err, e_data});
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: got no req_ready expected accept");
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL done_timeout: got %0d pending expected 0", exp_q.size());
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp_valid();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL rsp_wait: got rsp_valid=0 expected 1");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b1;

        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_cyc", 64'(bus.CYC), 64'd0);
        check("rst_stb", 64'(bus.STB), 64'd0);
        check("rst_we", 64'(bus.WE), 64'd0);
        check("rst_adr", 64'(bus.ADR), 64'd0);
        check("rst_dat_w", 64'(bus.DAT_W), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write then read, zero-wait target.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        wait_done();
        check("wr_cyc_len", 64'(last_cyc_len), 64'd2);
        check("wr_latency", 64'(last_rsp_cyc - last_acc_cyc - 1), 64'd2);
        issue(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        wait_done();
        check("rd_cyc_len", 64'(last_cyc_len), 64'd2);

        // Back-to-back: 8 writes then 8 reads.
        acc_q.delete();
        for (int i = 0; i < 8; i++)
            issue(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++)
            issue(1'b0, 32'(i * 4), 32'h0, 1'b1, 1'b0, 32'hA000_0000 + 32'(i));
        wait_done();
        check("b2b_accepts", 64'(acc_q.size()), 64'd16);
        for (int i = 1; i < acc_q.size(); i++)
            check("b2b_period", 64'(acc_q[i] - acc_q[i-1]), 64'd3);

        // Response backpressure.
        issue(1'b1, 32'h20, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
        wait_done();
        rsp_ready = 1'b0;
        issue(1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
        wait_rsp_valid();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_data", 64'(rsp_data), 64'h1234_5678);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_cyc", 64'(bus.CYC), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_done();
        @(negedge clk);
        check("bp_idle_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Timeout with a target that never acknowledges, then a late ACK.
        slave_never = 1'b1;
        issue(1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h0);
        wait_rsp_valid();
        check("to_err", 64'(rsp_err), 64'd1);
        check("to_cyc_len", 64'(last_cyc_len), 64'(TO));
        check("to_latency", 64'(last_rsp_cyc - last_acc_cyc - 1), 64'(TO));
        @(posedge clk);
        #1;
        late_ack = 1'b1;
        @(posedge clk);
        #1;
        late_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        wait_done();
        check("late_ack_no_cyc", 64'(bus.CYC), 64'd0);
        slave_never = 1'b0;

        // Three wait states.
        slave_waits = 3;
        issue(1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'hA000_0001);
        wait_done();
        check("ws_cyc_len", 64'(last_cyc_len), 64'd5);
        check("ws_latency", 64'(last_rsp_cyc - last_acc_cyc - 1), 64'd5);
        slave_waits = 0;

        // Reset one cycle after accept.
        issue(1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("mid_cyc_before", 64'(bus.CYC), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_cyc", 64'(bus.CYC), 64'd0);
        check("mid_stb", 64'(bus.STB), 64'd0);
        check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        issue(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
        wait_done();
        check("post_rst_cyc_len", 64'(last_cyc_len), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
